rat_out_port_ctrl: RTL and testbench
====================================

// Module: rat_out_port_ctrl
// PURPOSE
//  Output-direction I/O path of the RAT MCU, the counterpart of the register-file input select path.
//  Captures OUT_PORT/PORT_ID writes on IO_STRB into a small FIFO and drains them to peripherals:
//  register-mapped ports (LEDs, 7-seg) update immediately; streaming port (UART TX) uses valid/ready.
//  Sits between the control unit/register file and the board-level peripheral wrappers.
// PARAMETERS
//  FIFO_DEPTH  4      entries in the write FIFO; power of 2, >= 2
//  LEDS_ID     8'h40  PORT_ID of LED register port
//  SSEG_ID     8'h81  PORT_ID of 7-segment register port
//  TX_ID       8'h42  PORT_ID of UART TX stream port
// PORTS
//  CLK        in   1  system clock, all state on rising edge
//  RST        in   1  synchronous, active-high reset
//  PORT_ID    in   8  output port address from MCU
//  OUT_PORT   in   8  output data from register file
//  IO_STRB    in   1  one-cycle write strobe from control unit
//  IO_BUSY    out  1  FIFO full; writes presented now are dropped
//  IO_OVF     out  1  sticky: a mapped write was dropped while full
//  FIFO_LVL   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  LEDS       out  8  latched LED port value
//  SSEG       out  8  latched 7-segment port value
//  TX_DATA    out  8  stream byte to UART TX
//  TX_VALID   out  1  TX_DATA valid
//  TX_READY   in   1  UART TX accepts byte when TX_VALID && TX_READY
//  RDBACK     out  8  readback of port selected by PORT_ID (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; FSM IDLE; IO_OVF cleared. Reset mid-transfer aborts TX (TX_VALID low next cycle).
//  Write filter: IO_STRB with PORT_ID not in {LEDS_ID,SSEG_ID,TX_ID} ignored, never enqueued, no OVF.
//  Push: mapped IO_STRB && !IO_BUSY stores {PORT_ID,OUT_PORT} at tail on that edge.
//  Full: IO_BUSY = (FIFO_LVL == FIFO_DEPTH), from registered count; push while full is dropped
//   even if a pop occurs same cycle; dropped mapped write sets IO_OVF (cleared only by RST).
//  Simultaneous push+pop when not full: both happen, FIFO_LVL unchanged. Pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, TX_WAIT.
//   IDLE, FIFO non-empty, head reg port: write LEDS/SSEG from head data, pop; stay IDLE.
//   IDLE, head TX port: register TX_DATA <= head data, TX_VALID <= 1, go TX_WAIT (no pop yet).
//   TX_WAIT: hold TX_DATA/TX_VALID stable; on TX_VALID && TX_READY pop, TX_VALID <= 0, go IDLE.
//  Latency: strobe sampled at edge k -> LEDS/SSEG visible after edge k+1; TX_VALID high after edge k+1.
//  Back-to-back reg writes drain at 1/cycle; each TX byte costs >= 2 cycles (one bubble in IDLE).
//  Order preserved: a reg write queued behind a TX byte waits until that byte is accepted.
// CONFIGURATION
//  OUT_RDBACK_EN defined: RDBACK = LEDS if PORT_ID==LEDS_ID, SSEG if PORT_ID==SSEG_ID, else 8'h00
//   (combinational, reflects latched value, not pending FIFO entries); feeds IN_PORT readback.
//  OUT_RDBACK_EN undefined: RDBACK tied to 8'h00; no readback logic synthesized.
// STRUCTURE
//  Package rat_io_pkg: LEDS_ID/SSEG_ID/TX_ID default constants, fifo entry struct {id[7:0],data[7:0]},
//   FSM state enum {IDLE, TX_WAIT}.
//  Sub-module rat_out_fifo: synchronous FIFO (push, pop, head, level, full, empty), sync active-high reset.
//  Top holds write filter, OVF flag, drain FSM, LEDS/SSEG registers, readback mux.
// TESTING
//  1 STRB PORT_ID=40 OUT_PORT=A5 at edge k -> LEDS=A5 after k+1, FIFO_LVL back to 0, SSEG=00.
//  2 STRB id=42 data=3C, TX_READY=0 for 5 cycles -> TX_VALID=1, TX_DATA=3C held; READY=1 -> pop, VALID=0.
//  3 TX_READY=0; write id=42 x4 then id=40 data=11 -> IO_BUSY=1, 5th dropped, IO_OVF=1, LEDS stays 00.
//  4 STRB id=42 data=01 then id=81 data=7E, TX_READY=0 -> SSEG stays 00 until TX accepted, then 7E next edge.
//  5 STRB PORT_ID=99 -> no enqueue, FIFO_LVL=0, IO_OVF=0; assert RST during TX_WAIT -> all outputs 0.
//  6 OUT_RDBACK_EN: LEDS=A5, PORT_ID=40 -> RDBACK=A5; PORT_ID=42 -> 00; undefined build -> RDBACK=00 always.

Source files
------------

// File: rtl/rat_io_pkg.sv
// rat_io_pkg
//   Shared definitions for the RAT MCU output-port path.
//   - DEF_LEDS_ID / DEF_SSEG_ID / DEF_TX_ID : default PORT_ID values of the mapped ports
//   - fifo_entry_t  : one queued write, {id, data}
//   - drain_state_t : states of the FIFO drain FSM
package rat_io_pkg;

    localparam logic [7:0] DEF_LEDS_ID = 8'h40;
    localparam logic [7:0] DEF_SSEG_ID = 8'h81;
    localparam logic [7:0] DEF_TX_ID   = 8'h42;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] data;
    } fifo_entry_t;

    typedef enum logic {
        IDLE,
        TX_WAIT
    } drain_state_t;

endpackage

// File: rtl/rat_out_fifo.sv
// rat_out_fifo
//   Synchronous FIFO holding pending output-port writes.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//     push       : store wr_entry at the tail (ignored while full)
//     wr_entry   : entry to store
//     pop        : discard the head entry (ignored while empty)
//     head       : entry at the head of the queue
//     level      : current occupancy, 0..DEPTH
//     full/empty : occupancy flags derived from the registered level
//   DEPTH must be a power of 2 so that the pointers wrap naturally.
import rat_io_pkg::*;

module rat_out_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  fifo_entry_t             wr_entry,
    input  logic                    pop,
    output fifo_entry_t             head,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array has no reset; entries are only read once the level says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rat_out_port_ctrl.sv
// rat_out_port_ctrl
//   Output-direction I/O path of the RAT MCU. Writes strobed by the control unit are
//   filtered by PORT_ID, queued, and drained in order: register ports (LEDs, 7-seg)
//   update as soon as they reach the head, the UART TX stream port uses valid/ready.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     port_id, out_port : address and data of the MCU write
//     io_strb           : one-cycle write strobe
//     io_busy           : FIFO full, writes presented now are dropped
//     io_ovf            : sticky flag, a mapped write was dropped (cleared by rst only)
//     fifo_lvl          : FIFO occupancy
//     leds, sseg        : latched register-port values
//     tx_data, tx_valid : stream byte to UART TX
//     tx_ready          : UART TX accepts the byte when tx_valid && tx_ready
//     rdback            : readback of the register port selected by port_id
//   Build option: define OUT_RDBACK_EN to enable the readback mux; otherwise rdback is 0.
import rat_io_pkg::*;

module rat_out_port_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] LEDS_ID    = DEF_LEDS_ID,
    parameter logic [7:0] SSEG_ID    = DEF_SSEG_ID,
    parameter logic [7:0] TX_ID      = DEF_TX_ID
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    port_id,
    input  logic [7:0]                    out_port,
    input  logic                          io_strb,
    output logic                          io_busy,
    output logic                          io_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl,
    output logic [7:0]                    leds,
    output logic [7:0]                    sseg,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [7:0]                    rdback
);

    drain_state_t state;
    fifo_entry_t  wr_entry;
    fifo_entry_t  head;
    logic         mapped;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;

    assign mapped   = (port_id == LEDS_ID) || (port_id == SSEG_ID) || (port_id == TX_ID);
    assign push     = io_strb && mapped && !full;
    assign wr_entry = '{id: port_id, data: out_port};
    assign io_busy  = full;

    rat_out_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .head     (head),
        .level    (fifo_lvl),
        .full     (full),
        .empty    (empty)
    );

    // A register-port head is consumed immediately; a TX head stays queued until the
    // handshake completes, which is what keeps later writes ordered behind it.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !empty && (head.id != TX_ID);
            TX_WAIT: pop = tx_valid && tx_ready;
        endcase
    end

    // A drop is judged against the registered full flag, so a pop in the same cycle does not rescue it.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_ovf <= 1'b0;
        end else if (io_strb && mapped && full) begin
            io_ovf <= 1'b1;
        end
    end

    // Drain FSM: register-port updates and the TX handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            leds     <= 8'h00;
            sseg     <= 8'h00;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head.id == TX_ID) begin
                            tx_data  <= head.data;
                            tx_valid <= 1'b1;
                            state    <= TX_WAIT;
                        end else if (head.id == LEDS_ID) begin
                            leds <= head.data;
                        end else if (head.id == SSEG_ID) begin
                            sseg <= head.data;
                        end
                    end
                end
                TX_WAIT: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef OUT_RDBACK_EN
    // Reflects the latched port values only, not writes still waiting in the FIFO.
    always_comb begin
        rdback = 8'h00;
        if (port_id == LEDS_ID) begin
            rdback = leds;
        end else if (port_id == SSEG_ID) begin
            rdback = sseg;
        end
    end
`else
    assign rdback = 8'h00;
`endif

endmodule

// File: tb/tb_rat_out_port_ctrl.sv
// tb_rat_out_port_ctrl
//   Directed bench for rat_out_port_ctrl: reset state, register-port writes, TX
//   handshake, overflow, ordering behind TX, back-to-back drain, unmapped writes,
//   reset during TX and readback. Inputs change on the falling edge; outputs are
//   sampled on the falling edge, half a cycle away from the active edge.
module tb_rat_out_port_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;
    logic       io_busy;
    logic       io_ovf;
    logic [2:0] fifo_lvl;
    logic [7:0] leds;
    logic [7:0] sseg;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rdback;

    int checks   = 0;
    int failures = 0;

    rat_out_port_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .port_id  (port_id),
        .out_port (out_port),
        .io_strb  (io_strb),
        .io_busy  (io_busy),
        .io_ovf   (io_ovf),
        .fifo_lvl (fifo_lvl),
        .leds     (leds),
        .sseg     (sseg),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rdback   (rdback)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait ever runs away.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Two cycles of reset; returns on a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        io_strb  = 1'b0;
        tx_ready = 1'b0;
        port_id  = 8'h00;
        out_port = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle strobe; returns on the falling edge just after the capturing edge.
    task automatic strobe(input logic [7:0] id, input logic [7:0] d);
        @(negedge clk);
        port_id  = id;
        out_port = d;
        io_strb  = 1'b1;
        @(negedge clk);
        io_strb = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (leds !== 8'h00) begin failures++; $display("FAIL reset_leds: got %h expected %h", leds, 8'h00); end
        checks++; if (sseg !== 8'h00) begin failures++; $display("FAIL reset_sseg: got %h expected %h", sseg, 8'h00); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected %h", tx_data, 8'h00); end
        checks++; if (fifo_lvl !== 3'd0) begin failures++; $display("FAIL reset_lvl: got %0d expected 0", fifo_lvl); end
        checks++; if (io_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", io_busy); end
        checks++; if (io_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", io_ovf); end
    endtask

    task automatic test_leds_write();
        strobe(8'h40, 8'hA5);
        checks++; if (fifo_lvl !== 3'd1) begin failures++; $display("FAIL leds_lvl_queued: got %0d expected 1", fifo_lvl); end
        checks++; if (leds !== 8'h00) begin failures++; $display("FAIL leds_not_yet: got %h expected %h", leds, 8'h00); end
        @(negedge clk);
        checks++; if (leds !== 8'hA5) begin failures++; $display("FAIL leds_value: got %h expected %h", leds, 8'hA5); end
        checks++; if (fifo_lvl !== 3'd0) begin failures++; $display("FAIL leds_lvl_drained: got %0d expected 0", fifo_lvl); end
        checks++; if (sseg !== 8'h00) begin failures++; $display("FAIL leds_sseg_untouched: got %h expected %h", sseg, 8'h00); end
    endtask

    task automatic test_tx_handshake();
        tx_ready = 1'b0;
        strobe(8'h42, 8'h3C);
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_valid_early: got %b expected 0", tx_valid); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL tx_valid_rise: got %b expected 1", tx_valid); end
        checks++; if (tx_data !== 8'h3C) begin failures++; $display("FAIL tx_data_first: got %h expected %h", tx_data, 8'h3C); end
        repeat (5) @(negedge clk);
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL tx_valid_held: got %b expected 1", tx_valid); end
        checks++; if (tx_data !== 8'h3C) begin failures++; $display("FAIL tx_data_held: got %h expected %h", tx_data, 8'h3C); end
        checks++; if (fifo_lvl !== 3'd1) begin failures++; $display("FAIL tx_lvl_held: got %0d expected 1", fifo_lvl); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_valid_fall: got %b expected 0", tx_valid); end
        checks++; if (fifo_lvl !== 3'd0) begin failures++; $display("FAIL tx_lvl_popped: got %0d expected 0", fifo_lvl); end
    endtask

    task automatic test_overflow();
        logic [7:0] got [$];
        logic [7:0] exp_bytes [4];
        bit         done;
        exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            port_id  = (i < 4) ? 8'h42 : 8'h40;
            out_port = (i < 4) ? 8'(i + 1) : 8'h11;
            io_strb  = 1'b1;
        end
        @(negedge clk);
        io_strb = 1'b0;
        checks++; if (io_busy !== 1'b1) begin failures++; $display("FAIL ovf_busy: got %b expected 1", io_busy); end
        checks++; if (io_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", io_ovf); end
        checks++; if (fifo_lvl !== 3'd4) begin failures++; $display("FAIL ovf_lvl_full: got %0d expected 4", fifo_lvl); end
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL ovf_tx_valid: got %b expected 1", tx_valid); end
        // Push while full with a pop in the same cycle: pop happens, push is dropped.
        port_id  = 8'h40;
        out_port = 8'h22;
        io_strb  = 1'b1;
        tx_ready = 1'b1;
        got.push_back(tx_data);
        @(negedge clk);
        io_strb = 1'b0;
        checks++; if (fifo_lvl !== 3'd3) begin failures++; $display("FAIL ovf_full_pushpop_lvl: got %0d expected 3", fifo_lvl); end
        checks++; if (io_busy !== 1'b0) begin failures++; $display("FAIL ovf_busy_clear: got %b expected 0", io_busy); end
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (fifo_lvl == 3'd0 && !tx_valid) begin
                done = 1'b1;
            end else begin
                if (tx_valid) got.push_back(tx_data);
                @(negedge clk);
            end
        end
        tx_ready = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ovf_drain_timeout: got %b expected 1", done); end
        checks++; if (got.size() != 4) begin failures++; $display("FAIL ovf_tx_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_bytes[i]) begin failures++; $display("FAIL ovf_tx_order%0d: got %h expected %h", i, got[i], exp_bytes[i]); end
        end
        checks++; if (leds !== 8'h00) begin failures++; $display("FAIL ovf_leds_dropped: got %h expected %h", leds, 8'h00); end
        checks++; if (io_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", io_ovf); end
        do_reset();
        checks++; if (io_ovf !== 1'b0) begin failures++; $display("FAIL ovf_cleared_by_reset: got %b expected 0", io_ovf); end
    endtask

    task automatic test_order();
        do_reset();
        strobe(8'h42, 8'h01);
        strobe(8'h81, 8'h7E);
        repeat (3) @(negedge clk);
        checks++; if (sseg !== 8'h00) begin failures++; $display("FAIL order_sseg_waits: got %h expected %h", sseg, 8'h00); end
        checks++; if (tx_data !== 8'h01) begin failures++; $display("FAIL order_tx_data: got %h expected %h", tx_data, 8'h01); end
        checks++; if (fifo_lvl !== 3'd2) begin failures++; $display("FAIL order_lvl: got %0d expected 2", fifo_lvl); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL order_tx_done: got %b expected 0", tx_valid); end
        checks++; if (sseg !== 8'h00) begin failures++; $display("FAIL order_sseg_bubble: got %h expected %h", sseg, 8'h00); end
        @(negedge clk);
        checks++; if (sseg !== 8'h7E) begin failures++; $display("FAIL order_sseg_value: got %h expected %h", sseg, 8'h7E); end
        checks++; if (fifo_lvl !== 3'd0) begin failures++; $display("FAIL order_lvl_empty: got %0d expected 0", fifo_lvl); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        port_id = 8'h40; out_port = 8'h11; io_strb = 1'b1;
        @(negedge clk);
        port_id = 8'h81; out_port = 8'h22;
        @(negedge clk);
        checks++; if (leds !== 8'h11) begin failures++; $display("FAIL b2b_leds_first: got %h expected %h", leds, 8'h11); end
        port_id = 8'h40; out_port = 8'h33;
        @(negedge clk);
        io_strb = 1'b0;
        checks++; if (sseg !== 8'h22) begin failures++; $display("FAIL b2b_sseg: got %h expected %h", sseg, 8'h22); end
        checks++; if (fifo_lvl !== 3'd1) begin failures++; $display("FAIL b2b_lvl: got %0d expected 1", fifo_lvl); end
        @(negedge clk);
        checks++; if (leds !== 8'h33) begin failures++; $display("FAIL b2b_leds_second: got %h expected %h", leds, 8'h33); end
        checks++; if (fifo_lvl !== 3'd0) begin failures++; $display("FAIL b2b_lvl_empty: got %0d expected 0", fifo_lvl); end
    endtask

    task automatic test_unmapped_and_reset();
        do_reset();
        strobe(8'h99, 8'h55);
        checks++; if (fifo_lvl !== 3'd0) begin failures++; $display("FAIL unmapped_lvl: got %0d expected 0", fifo_lvl); end
        @(negedge clk);
        checks++; if ({leds, sseg} !== 16'h0000) begin failures++; $display("FAIL unmapped_ports: got %h expected %h", {leds, sseg}, 16'h0000); end
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            port_id  = (i < 4) ? 8'h42 : 8'h99;
            out_port = 8'hA0 + 8'(i);
            io_strb  = 1'b1;
        end
        @(negedge clk);
        io_strb = 1'b0;
        checks++; if (io_ovf !== 1'b0) begin failures++; $display("FAIL unmapped_full_ovf: got %b expected 0", io_ovf); end
        checks++; if (fifo_lvl !== 3'd4) begin failures++; $display("FAIL unmapped_full_lvl: got %0d expected 4", fifo_lvl); end
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL unmapped_tx_wait: got %b expected 1", tx_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_mid_tx_data: got %h expected %h", tx_data, 8'h00); end
        checks++; if (fifo_lvl !== 3'd0) begin failures++; $display("FAIL rst_mid_lvl: got %0d expected 0", fifo_lvl); end
        checks++; if (io_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", io_busy); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_no_restart: got %b expected 0", tx_valid); end
    endtask

    task automatic test_rdback();
        logic [7:0] exp_leds;
`ifdef OUT_RDBACK_EN
        exp_leds = 8'hA5;
`else
        exp_leds = 8'h00;
`endif
        do_reset();
        strobe(8'h40, 8'hA5);
        @(negedge clk);
        port_id = 8'h40;
        #1;
        checks++; if (rdback !== exp_leds) begin failures++; $display("FAIL rdback_leds: got %h expected %h", rdback, exp_leds); end
        port_id = 8'h42;
        #1;
        checks++; if (rdback !== 8'h00) begin failures++; $display("FAIL rdback_tx_id: got %h expected %h", rdback, 8'h00); end
        port_id = 8'h81;
        #1;
        checks++; if (rdback !== 8'h00) begin failures++; $display("FAIL rdback_sseg: got %h expected %h", rdback, 8'h00); end
    endtask

    initial begin
        rst      = 1'b1;
        io_strb  = 1'b0;
        tx_ready = 1'b0;
        port_id  = 8'h00;
        out_port = 8'h00;
        $display("[TB] start");
        test_reset();
        test_leds_write();
        test_tx_handshake();
        test_overflow();
        test_order();
        test_back_to_back();
        test_unmapped_and_reset();
        test_rdback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
